uart_frame_parser: RTL and testbench

- Sits directly downstream of the UART receiver and consumes its byte stream (8-bit data plus a single-cycle valid strobe).
- Delineates command frames: SOF, LEN, LEN payload bytes, then an XOR checksum byte.
- Forwards each payload byte as it arrives and flags the frame end as good or bad.
- The UART cannot be stalled, so the block has no backpressure; it must accept a byte on every i_valid.

---
 rtl/uart_frame_parser.sv | 123 ++++++++++++
 tb/tb_uart_frame_parser.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Command-frame delineator behind the UART receiver: SOF, LEN, LEN payload bytes, XOR checksum.
// Payload is forwarded as it arrives; the frame end is flagged good or bad with no backpressure.
module uart_frame_parser #(
  parameter logic [7:0]  SOF         = 8'hA5,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_last,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CHECK   = 2'd3;

  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [7:0]       len, rcv_cnt, chk;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             len_bad;
  logic             pay_last;

  // An arriving byte always beats the terminal count.
  assign tmo_hit  = (state != ST_IDLE) && !i_valid && (tmo_cnt == TMO_LAST);
  assign len_bad  = (i_data == 8'd0) || (i_data > MAX_LEN_B);
  assign pay_last = ((rcv_cnt + 8'd1) == len);

  always_comb begin
    state_nxt = state;
    if (tmo_hit) begin
      state_nxt = ST_IDLE;
    end else if (i_valid) begin
      case (state)
        ST_IDLE:    if (i_data == SOF) state_nxt = ST_LEN;
        ST_LEN:     state_nxt = len_bad ? ST_IDLE : ST_PAYLOAD;
        ST_PAYLOAD: if (pay_last) state_nxt = ST_CHECK;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= ST_IDLE;
      len         <= '0;
      rcv_cnt     <= '0;
      chk         <= '0;
      tmo_cnt     <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code  <= '0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_busy      <= (state_nxt != ST_IDLE);
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;

      if (i_valid || state_nxt == ST_IDLE) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end

      if (tmo_hit) begin
        o_frame_err <= 1'b1;
        o_err_code  <= ERR_TMO;
      end else if (i_valid) begin
        case (state)
          ST_LEN: begin
            len     <= i_data;
            chk     <= i_data;
            rcv_cnt <= '0;
            if (len_bad) begin
              o_frame_err <= 1'b1;
              o_err_code  <= ERR_LEN;
            end
          end
          ST_PAYLOAD: begin
            chk     <= chk ^ i_data;
            rcv_cnt <= rcv_cnt + 8'd1;
            o_data  <= i_data;
            o_valid <= 1'b1;
            o_last  <= pay_last;
          end
          ST_CHECK: begin
            if (i_data == chk) begin
              o_frame_ok <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
              o_err_code  <= ERR_CHK;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed and random byte streams against a frame-scanning model.
module tb_uart_frame_parser;

  localparam logic [7:0]  SOF     = 8'hA5;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned T       = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic [7:0] o_data;
  logic       o_valid, o_last, o_frame_ok, o_frame_err, o_busy;
  logic [1:0] o_err_code;

  uart_frame_parser #(
    .SOF(SOF),
    .MAX_LEN(MAX_LEN),
    .TIMEOUT_CYC(T),
    .CNT_W(6)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_last(o_last),
    .o_frame_ok(o_frame_ok),
    .o_frame_err(o_frame_err),
    .o_err_code(o_err_code),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // kind: 0 payload byte, 1 frame ok, 2 frame error, 3 stray o_last
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic       last;
    logic [1:0] code;
  } ev_t;

  ev_t             exp_q[$];
  ev_t             obs_q[$];
  logic [7:0]      stim_b[$];
  int unsigned     stim_g[$];
  int              n_checks = 0;
  int              n_pass   = 0;
  int              n_fail   = 0;

  function automatic ev_t mk(input logic [1:0] k, input logic [7:0] d, input logic l,
                             input logic [1:0] c);
    ev_t e;
    e.kind = k; e.data = d; e.last = l; e.code = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid)           obs_q.push_back(mk(2'd0, o_data, o_last, 2'd0));
      if (o_last && !o_valid) obs_q.push_back(mk(2'd3, 8'd0, 1'b1, 2'd0));
      if (o_frame_ok)        obs_q.push_back(mk(2'd1, 8'd0, 1'b0, 2'd0));
      if (o_frame_err)       obs_q.push_back(mk(2'd2, 8'd0, 1'b0, o_err_code));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    i_valid = v;
    i_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] b, input int unsigned g);
    stim_b.push_back(b);
    stim_g.push_back(g);
  endtask

  // Scans the stream frame by frame; a gap of T or more idle cycles inside a frame aborts it,
  // and the late byte is then looked at as if the parser were idle.
  task automatic build_expected();
    int unsigned n = stim_b.size();
    int unsigned i = 0;
    int unsigned k;
    logic [7:0]  len, x;
    bit          ab;
    exp_q.delete();
    while (i < n) begin
      if (stim_b[i] != SOF) begin
        i++;
        continue;
      end
      k = i + 1;
      if (k >= n || stim_g[k] >= T) begin
        exp_q.push_back(mk(2'd2, 8'd0, 1'b0, 2'd3));
        i = k;
        continue;
      end
      len = stim_b[k];
      k++;
      if (len == 8'd0 || int'(len) > int'(MAX_LEN)) begin
        exp_q.push_back(mk(2'd2, 8'd0, 1'b0, 2'd1));
        i = k;
        continue;
      end
      x  = len;
      ab = 1'b0;
      for (int p = 0; p < int'(len); p++) begin
        if (k >= n || stim_g[k] >= T) begin
          ab = 1'b1;
          break;
        end
        x ^= stim_b[k];
        exp_q.push_back(mk(2'd0, stim_b[k], p == int'(len) - 1, 2'd0));
        k++;
      end
      if (ab || k >= n || stim_g[k] >= T) begin
        exp_q.push_back(mk(2'd2, 8'd0, 1'b0, 2'd3));
        i = k;
        continue;
      end
      if (stim_b[k] == x) exp_q.push_back(mk(2'd1, 8'd0, 1'b0, 2'd0));
      else                exp_q.push_back(mk(2'd2, 8'd0, 1'b0, 2'd2));
      i = k + 1;
    end
  endtask

  task automatic run_stream(input string tag);
    build_expected();
    obs_q.delete();
    for (int i = 0; i < stim_b.size(); i++) begin
      repeat (stim_g[i]) cycle(1'b0, 8'($urandom));
      cycle(1'b1, stim_b[i]);
    end
    repeat (T + 4) cycle(1'b0, 8'($urandom));
    check({tag, " event count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, " event"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, " idle busy"}, 32'(o_busy), 32'd0);
    stim_b.delete();
    stim_g.delete();
  endtask

  function automatic int unsigned rgap();
    int unsigned r = $urandom_range(0, 39);
    if (r == 0) return T - 1;
    if (r == 1) return T;
    return $urandom_range(0, 2);
  endfunction

  function automatic logic [7:0] rbyte(input bit allow_sof);
    logic [7:0] b = 8'($urandom);
    if (allow_sof && $urandom_range(0, 7) == 0) b = SOF;
    if (!allow_sof && b == SOF) b = 8'h5A;
    return b;
  endfunction

  task automatic gen_random(input int unsigned nfr);
    int unsigned kind, l;
    logic [7:0]  x, b;
    for (int unsigned f = 0; f < nfr; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        add(rbyte(1'b0), rgap());
      end else if (kind == 1) begin
        add(SOF, rgap());
        if ($urandom_range(0, 1) == 0) add(8'd0, rgap());
        else add(8'($urandom_range(MAX_LEN + 1, 255)), rgap());
      end else begin
        l = $urandom_range(1, MAX_LEN);
        add(SOF, rgap());
        add(8'(l), rgap());
        x = 8'(l);
        for (int unsigned p = 0; p < l; p++) begin
          b = rbyte(1'b1);
          x ^= b;
          add(b, rgap());
        end
        if (kind == 2) x ^= 8'(1 << $urandom_range(0, 7));
        add(x, rgap());
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    #12;
    check("reset outputs",
          32'({o_data, o_valid, o_last, o_frame_ok, o_frame_err, o_err_code, o_busy}), 32'd0);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00);

    // good frame, cycle by cycle
    cycle(1'b1, SOF);
    cycle(1'b1, 8'h03);
    check("busy in frame", 32'(o_busy), 32'd1);
    cycle(1'b1, 8'h11);
    check("first payload", 32'({o_valid, o_last, o_data}), 32'({1'b1, 1'b0, 8'h11}));
    cycle(1'b1, 8'h22);
    check("second payload", 32'({o_valid, o_last, o_data}), 32'({1'b1, 1'b0, 8'h22}));
    cycle(1'b1, 8'h33);
    check("last payload", 32'({o_valid, o_last, o_data}), 32'({1'b1, 1'b1, 8'h33}));
    cycle(1'b1, 8'h03);
    check("frame ok pulse", 32'({o_valid, o_frame_ok, o_frame_err}), 32'({1'b0, 1'b1, 1'b0}));
    cycle(1'b0, 8'h00);
    check("frame ok one cycle", 32'({o_frame_ok, o_frame_err}), 32'd0);
    cycle(1'b0, 8'h00);
    check("busy after frame", 32'(o_busy), 32'd0);

    add(SOF, 0); add(8'h02, 0); add(8'h10, 0); add(8'h20, 0); add(8'h31, 0);
    run_stream("bad checksum");

    add(SOF, 0); add(8'h00, 0); add(SOF, 1); add(8'h11, 0); add(8'h55, 0); add(8'h66, 0);
    run_stream("bad length");
    check("err code holds", 32'(o_err_code), 32'd1);

    add(SOF, 0); add(8'h02, 0); add(8'hAA, 0);
    run_stream("timeout");
    check("timeout code", 32'(o_err_code), 32'd3);

    add(SOF, 0); add(8'h02, 0); add(8'hAA, 0); add(8'hBB, T - 1); add(8'h13, T - 1);
    run_stream("terminal count byte");

    add(SOF, 0); add(8'h02, 0); add(SOF, 0); add(SOF, 0); add(8'h02, 0);
    add(SOF, 0); add(8'h01, 0); add(8'h7E, 0); add(8'h7F, 0);
    run_stream("back to back");

    // reset in the middle of a frame
    cycle(1'b1, SOF);
    cycle(1'b1, 8'h03);
    cycle(1'b1, 8'h11);
    rst_n = 1'b0;
    #1;
    check("mid-frame reset outputs",
          32'({o_data, o_valid, o_last, o_frame_ok, o_frame_err, o_err_code, o_busy}), 32'd0);
    cycle(1'b0, 8'h00);
    rst_n = 1'b1;
    add(8'h22, 0); add(8'h33, 0); add(SOF, 0); add(8'h02, 0); add(8'h5A, 0); add(8'h3C, 0);
    add(8'h64, 0);
    run_stream("after reset");

    for (int r = 0; r < 6; r++) begin
      gen_random(12);
      run_stream("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
